// File: rtl/spi_frame_slave_if.sv
// Pin bundle between the off-chip SPI master / AES top level and spi_frame_slave.
// The slave modport is the frame receiver; the master modport drives select, data and done.
interface spi_frame_slave_if #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 8,
    parameter int LOC_W  = 8
);
    logic              ss;
    logic              mosi;
    logic              miso;
    logic              done;
    logic [KEY_W-1:0]  usr_key;
    logic [ADDR_W-1:0] usr_addr;
    logic [LOC_W-1:0]  usr_loc;
    logic              mode;
    logic              start;
    logic              busy;
    logic              frame_err;
    logic [1:0]        err_code;

    modport slave (
        input  ss, mosi, done,
        output miso, usr_key, usr_addr, usr_loc, mode, start, busy, frame_err, err_code
    );

    modport master (
        output ss, mosi, done,
        input  miso, usr_key, usr_addr, usr_loc, mode, start, busy, frame_err, err_code
    );
endinterface

// File: rtl/spi_frame_slave.sv
// SPI command slave: receives {loc, addr, key, mode} frames, launches the AES core and returns status.
// Optional trailing even-parity bit enabled with `define SPI_FRAME_PARITY_EN.
module spi_frame_slave #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 8,
    parameter int LOC_W  = 8
) (
    input logic              clk,
    input logic              n_rst,
    spi_frame_slave_if.slave bus
);
    localparam int FRAME_LEN = LOC_W + ADDR_W + KEY_W + 1;
`ifdef SPI_FRAME_PARITY_EN
    localparam int VALID_LEN = FRAME_LEN + 1;
`else
    localparam int VALID_LEN = FRAME_LEN;
`endif
    localparam int CNT_MAX = VALID_LEN + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] VALID_CNT = CNT_W'(VALID_LEN);
    localparam logic [CNT_W-1:0] SAT_CNT   = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     bit_cnt;
    logic [VALID_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] frame_data;
    logic [7:0]           status_live;
    logic [7:0]           status_snap;
    logic [4:0]           acc_cnt;
    logic                 parity_ok;
    logic                 eff_busy;
    logic                 sample;
    logic                 load_first;
    logic                 accept;
    logic                 reject;
    logic [1:0]           rej_code;
    logic                 miso_bit;

    assign frame_data  = shreg[VALID_LEN-1 -: FRAME_LEN];
`ifdef SPI_FRAME_PARITY_EN
    assign parity_ok   = ~^shreg;
`else
    assign parity_ok   = 1'b1;
`endif
    assign eff_busy    = bus.busy & ~bus.done;
    assign status_live = {bus.busy, bus.err_code, acc_cnt};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sample     = 1'b0;
        load_first = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        rej_code   = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.ss) begin
                    sample     = 1'b1;
                    load_first = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!bus.ss) sample  = 1'b1;
                else         state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (bit_cnt < VALID_CNT) begin
                    reject   = 1'b1;
                    rej_code = 2'b01;
                end else if (bit_cnt > VALID_CNT) begin
                    reject   = 1'b1;
                    rej_code = 2'b10;
                end else if (!parity_ok) begin
                    reject   = 1'b1;
                    rej_code = 2'b01;
                end else if (eff_busy) begin
                    reject   = 1'b1;
                    rej_code = 2'b11;
                end else begin
                    accept   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            bit_cnt       <= '0;
            status_snap   <= '0;
            acc_cnt       <= '0;
            bus.usr_key   <= '0;
            bus.usr_addr  <= '0;
            bus.usr_loc   <= '0;
            bus.mode      <= 1'b0;
            bus.start     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err_code  <= 2'b00;
        end else begin
            state_q       <= state_d;
            bus.start     <= accept;
            bus.frame_err <= reject;
            if (load_first) begin
                bit_cnt     <= CNT_W'(1);
                status_snap <= status_live;
            end else if (sample && bit_cnt != SAT_CNT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // An acceptance re-arms busy even if done clears it on the same edge.
            if (accept) begin
                bus.usr_loc  <= frame_data[FRAME_LEN-1 -: LOC_W];
                bus.usr_addr <= frame_data[KEY_W+ADDR_W:KEY_W+1];
                bus.usr_key  <= frame_data[KEY_W:1];
                bus.mode     <= frame_data[0];
                bus.busy     <= 1'b1;
                bus.err_code <= 2'b00;
                acc_cnt      <= acc_cnt + 5'd1;
            end else begin
                if (bus.busy && bus.done) bus.busy <= 1'b0;
                if (reject) bus.err_code <= rej_code;
            end
        end
    end

    // NOTE: the shift register is pure datapath with no reset; a frame is only used once all its bits are written.
    always_ff @(posedge clk) begin
        if (sample) shreg <= {shreg[VALID_LEN-2:0], bus.mosi};
    end

    // Idle shows the live busy bit; once shifting, the snapshot walks out MSB first.
    always_comb begin
        miso_bit = 1'b0;
        if (state_q == S_IDLE)       miso_bit = status_live[7];
        else if (int'(bit_cnt) < 8)  miso_bit = status_snap[~bit_cnt[2:0]];
    end

    assign bus.miso = miso_bit;
endmodule
